lfsr_seqgen: RTL

Runtime-configurable maximal-length PN sequence generator for the channel sounder transmit path. Holds the Galois tap table internally, loads the mask and period for a selectable degree, and emits one chip per `strobe_i` with a period-start marker. Degree changes are deferred to a period boundary so the receiver's correlator never sees a truncated sequence. Supersedes the standalone mask/length constant lookup.

---
 rtl/lfsr_pkg.sv | 35 +++
 rtl/lfsr_mask_rom.sv | 44 ++++
 rtl/lfsr_seqgen.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants, state encoding and Galois tap table for the PN generator
package lfsr_pkg;

    localparam int LFSR_MAX_DEGREE = 16;
    localparam int LFSR_TABLE_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } lfsr_state_t;

    // Galois-form maximal-length taps; 0 marks an unsupported degree.
    function automatic logic [LFSR_TABLE_W-1:0] lfsr_mask(input int unsigned degree);
        case (degree)
            2:       return 16'h0003;
            3:       return 16'h0005;
            4:       return 16'h0009;
            5:       return 16'h0012;
            6:       return 16'h0021;
            7:       return 16'h0041;
            8:       return 16'h008E;
            9:       return 16'h0108;
            10:      return 16'h0204;
            11:      return 16'h0402;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h4001;
            16:      return 16'h8016;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_mask_rom.sv
// rtl/lfsr_mask_rom.sv - registered degree to {mask, period, legal} lookup
// Ports: i_clk, i_rst (async, active-high), i_degree (requested degree);
//        o_mask (tap mask), o_len (2**degree-1), o_legal, o_degree (degree the outputs belong to).
module lfsr_mask_rom
    import lfsr_pkg::*;
#(
    parameter int MAX_DEGREE = LFSR_MAX_DEGREE,
    parameter int DEG_W      = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DEG_W-1:0]      i_degree,
    output logic [MAX_DEGREE-1:0] o_mask,
    output logic [MAX_DEGREE-1:0] o_len,
    output logic                  o_legal,
    output logic [DEG_W-1:0]      o_degree
);

    logic                  w_legal;
    logic [MAX_DEGREE-1:0] w_mask;
    logic [MAX_DEGREE:0]   w_pow;
    logic [MAX_DEGREE-1:0] w_len;

    assign w_legal = (int'(i_degree) <= MAX_DEGREE) && (lfsr_mask(32'(i_degree)) != '0);
    assign w_mask  = MAX_DEGREE'(lfsr_mask(32'(i_degree)));
    assign w_pow   = {{MAX_DEGREE{1'b0}}, 1'b1} << i_degree;
    // Truncating (1 << degree) - 1 to MAX_DEGREE bits keeps the top degree exact.
    assign w_len   = MAX_DEGREE'(w_pow - 1'b1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mask   <= '0;
            o_len    <= '0;
            o_legal  <= 1'b0;
            o_degree <= '0;
        end else begin
            o_mask   <= w_legal ? w_mask : '0;
            o_len    <= w_legal ? w_len  : '0;
            o_legal  <= w_legal;
            o_degree <= i_degree;
        end
    end

endmodule

// File: rtl/lfsr_seqgen.sv
// rtl/lfsr_seqgen.sv - runtime-configurable maximal-length PN chip generator
// Ports: clk_i, rst_i (async, active-high), ena_i (run request), strobe_i (chip advance),
//        degree_i (requested degree); pn_o/valid_o/sync_o (chip, qualifier, period start),
//        mask_o/len_o (taps and period in use), busy_o (LOAD or RUN), err_o (illegal degree).
module lfsr_seqgen
    import lfsr_pkg::*;
#(
    parameter int MAX_DEGREE = LFSR_MAX_DEGREE,
    parameter int DEG_W      = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ena_i,
    input  logic                  strobe_i,
    input  logic [DEG_W-1:0]      degree_i,
    output logic                  pn_o,
    output logic                  valid_o,
    output logic                  sync_o,
    output logic [MAX_DEGREE-1:0] mask_o,
    output logic [MAX_DEGREE-1:0] len_o,
    output logic                  busy_o,
    output logic                  err_o
);

    lfsr_state_t           r_state;
    logic [MAX_DEGREE-1:0] r_lfsr;
    logic [MAX_DEGREE-1:0] r_cnt;
    logic [DEG_W-1:0]      r_deg;
    logic                  r_pend;
    logic                  r_pn;
    logic                  r_valid;
    logic                  r_sync;
    logic [MAX_DEGREE-1:0] r_mask;
    logic [MAX_DEGREE-1:0] r_len;
    logic                  r_busy;
    logic                  r_err;

    logic [MAX_DEGREE-1:0] w_rom_mask;
    logic [MAX_DEGREE-1:0] w_rom_len;
    logic                  w_rom_legal;
    logic [DEG_W-1:0]      w_rom_degree;
    logic                  w_legal_in;
    logic [MAX_DEGREE-1:0] w_next;
    logic                  w_wrap;

    lfsr_mask_rom #(
        .MAX_DEGREE (MAX_DEGREE),
        .DEG_W      (DEG_W)
    ) u_rom (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_degree (degree_i),
        .o_mask   (w_rom_mask),
        .o_len    (w_rom_len),
        .o_legal  (w_rom_legal),
        .o_degree (w_rom_degree)
    );

    assign w_legal_in = (int'(degree_i) <= MAX_DEGREE) && (lfsr_mask(32'(degree_i)) != '0);
    assign w_next     = r_lfsr[0] ? ((r_lfsr >> 1) ^ r_mask) : (r_lfsr >> 1);
    assign w_wrap     = (r_cnt == r_len - MAX_DEGREE'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_lfsr  <= '0;
            r_cnt   <= '0;
            r_deg   <= '0;
            r_pend  <= 1'b0;
            r_pn    <= 1'b0;
            r_valid <= 1'b0;
            r_sync  <= 1'b0;
            r_mask  <= '0;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_pn    <= 1'b0;
            r_valid <= 1'b0;
            r_sync  <= 1'b0;
            if (!ena_i) begin
                r_state <= ST_IDLE;
                r_lfsr  <= '0;
                r_cnt   <= '0;
                r_pend  <= 1'b0;
                r_mask  <= '0;
                r_len   <= '0;
                r_busy  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_err <= !w_legal_in;
                        if (w_legal_in) begin
                            r_state <= ST_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        // The ROM output reflects degree_i from the edge that chose LOAD.
                        if (w_rom_legal) begin
                            r_state <= ST_RUN;
                            r_deg   <= w_rom_degree;
                            r_mask  <= w_rom_mask;
                            r_len   <= w_rom_len;
                            r_lfsr  <= w_rom_len;   // seed: all-ones in the low degree bits
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                            r_mask  <= '0;
                            r_len   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (r_pend) begin
                            // Reconfiguration slot right after the wrap chip; strobes dropped.
                            r_pend <= 1'b0;
                            if (w_legal_in) begin
                                r_state <= ST_LOAD;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                                r_mask  <= '0;
                                r_len   <= '0;
                                r_lfsr  <= '0;
                                r_cnt   <= '0;
                            end
                        end else if (strobe_i) begin
                            r_valid <= 1'b1;
                            r_pn    <= r_lfsr[0];
                            r_sync  <= (r_cnt == '0);
                            if (w_wrap) begin
                                r_cnt  <= '0;
                                r_lfsr <= r_len;
                                r_pend <= (degree_i != r_deg);
                            end else begin
                                r_cnt  <= r_cnt + MAX_DEGREE'(1);
                                r_lfsr <= w_next;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pn_o    = r_pn;
    assign valid_o = r_valid;
    assign sync_o  = r_sync;
    assign mask_o  = r_mask;
    assign len_o   = r_len;
    assign busy_o  = r_busy;
    assign err_o   = r_err;

endmodule
